// File: rtl/bp_be_pkg.sv
// Back-end shared types for the D$ request arbiter slice.
// Provides the processor-config selector, the arbiter FSM state enum, and
// helper functions that map a config onto cache-service request widths.
package bp_be_pkg;

   typedef enum logic [1:0] {
      e_bp_default_cfg,
      e_bp_inv_cfg
   } bp_params_e;

   typedef enum logic [1:0] {
      e_idle,
      e_meta,
      e_wait
   } bp_be_cache_req_arb_state_e;

   // Width of one D$ request packet for a given config.
   function automatic int unsigned dcache_req_width_f(bp_params_e cfg);
      int unsigned w;
      w = 32;
      if (cfg == e_bp_inv_cfg) w = 16;
      return w;
   endfunction

   // Width of one D$ request metadata packet for a given config.
   function automatic int unsigned dcache_req_metadata_width_f(bp_params_e cfg);
      int unsigned w;
      w = 8;
      if (cfg == e_bp_inv_cfg) w = 4;
      return w;
   endfunction

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter.
//   clk_i, reset_i : clock, synchronous active-high reset
//   reqs_i         : request vector
//   grants_o       : one-hot grant (zero when no request)
//   v_o            : any request present
//   tag_o          : index of the granted requester
//   yumi_i         : grant consumed; advance the pointer past the winner
module bsg_arb_round_robin #(
   parameter int unsigned width_p = 2
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [width_p-1:0]         reqs_i,
   output logic [width_p-1:0]         grants_o,
   output logic                       v_o,
   output logic [$clog2(width_p)-1:0] tag_o,
   input  logic                       yumi_i
);

   localparam int unsigned id_width_lp = $clog2(width_p);

   // Index at which the next search begins.
   logic [id_width_lp-1:0] ptr_q, ptr_d;

   always_comb begin
      int unsigned            idx;
      logic [id_width_lp-1:0] idx_w;
      idx   = 0;
      idx_w = '0;
      tag_o = '0;
      v_o   = 1'b0;
      for (int unsigned i = 0; i < width_p; i++) begin
         idx   = (32'(ptr_q) + i) % width_p;
         idx_w = id_width_lp'(idx);
         if (!v_o && reqs_i[idx_w]) begin
            v_o   = 1'b1;
            tag_o = idx_w;
         end
      end
   end

   assign grants_o = v_o ? (width_p'(1) << tag_o) : '0;

   assign ptr_d = (tag_o == id_width_lp'(width_p - 1)) ? '0 : tag_o + 1'b1;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else if (yumi_i) begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bp_be_cache_req_arbiter.sv
// Shares one D$-LCE request port among num_req_p requesters.
// One transaction is outstanding at a time: request handshake (e_idle),
// metadata forward from the owner (e_meta), then wait for LCE completion.
//   clk_i, reset_i                   : clock, synchronous active-high reset
//   req_i / req_v_i / req_ready_o    : per-requester request (flattened packets)
//   req_metadata_i / req_metadata_v_i: per-requester metadata (flattened)
//   req_complete_o                   : one-cycle completion pulse to owner
//   cache_req_*                      : shared request/metadata port to the LCE
//   cache_req_complete_i             : LCE completion of the outstanding request
//   busy_o                           : a transaction is in flight
//   grant_id_o                       : current or last owner
module bp_be_cache_req_arbiter
   import bp_be_pkg::*;
#(
   parameter bp_params_e  bp_params_p = e_bp_inv_cfg,
   parameter int unsigned num_req_p   = 2,
   localparam int unsigned dcache_req_width_lp          = dcache_req_width_f(bp_params_p),
   localparam int unsigned dcache_req_metadata_width_lp = dcache_req_metadata_width_f(bp_params_p),
   localparam int unsigned id_width_lp                  = $clog2(num_req_p)
) (
   input  logic                                              clk_i,
   input  logic                                              reset_i,

   input  logic [num_req_p*dcache_req_width_lp-1:0]          req_i,
   input  logic [num_req_p-1:0]                              req_v_i,
   output logic [num_req_p-1:0]                              req_ready_o,
   input  logic [num_req_p*dcache_req_metadata_width_lp-1:0] req_metadata_i,
   input  logic [num_req_p-1:0]                              req_metadata_v_i,
   output logic [num_req_p-1:0]                              req_complete_o,

   output logic [dcache_req_width_lp-1:0]                    cache_req_o,
   output logic                                              cache_req_v_o,
   input  logic                                              cache_req_ready_i,
   output logic [dcache_req_metadata_width_lp-1:0]           cache_req_metadata_o,
   output logic                                              cache_req_metadata_v_o,
   input  logic                                              cache_req_complete_i,

   output logic                                              busy_o,
   output logic [id_width_lp-1:0]                            grant_id_o
);

   bp_be_cache_req_arb_state_e state_q, state_d;
   logic [id_width_lp-1:0]     grant_id_q, grant_id_d;

   logic [num_req_p-1:0]   rr_grants;
   logic                   rr_v;
   logic [id_width_lp-1:0] rr_tag;
   logic                   handshake;
   logic                   owner_meta_v;

   assign handshake = (state_q == e_idle) & rr_v & cache_req_ready_i & ~reset_i;

   bsg_arb_round_robin #(
      .width_p (num_req_p)
   ) u_rr (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .reqs_i   (req_v_i),
      .grants_o (rr_grants),
      .v_o      (rr_v),
      .tag_o    (rr_tag),
      .yumi_i   (handshake)
   );

   // Owner-indexed metadata valid; non-owner valids never reach the port.
   assign owner_meta_v = req_metadata_v_i[grant_id_q];

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= e_idle;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      unique case (state_q)
         e_idle: begin
            if (handshake) begin
               state_d    = e_meta;
               grant_id_d = rr_tag;
            end
         end
         e_meta: begin
            // Completion wins over metadata: both together end the transaction.
            if (cache_req_complete_i) state_d = e_idle;
            else if (owner_meta_v)    state_d = e_wait;
         end
         e_wait: begin
            if (cache_req_complete_i) state_d = e_idle;
         end
         default: state_d = e_idle;
      endcase
   end

   always_comb begin
      cache_req_o            = '0;
      cache_req_metadata_o   = '0;
      cache_req_v_o          = 1'b0;
      cache_req_metadata_v_o = 1'b0;
      req_ready_o            = '0;
      req_complete_o         = '0;

      for (int unsigned i = 0; i < num_req_p; i++) begin
         if (rr_tag == id_width_lp'(i)) begin
            cache_req_o = req_i[i*dcache_req_width_lp +: dcache_req_width_lp];
         end
         if (grant_id_q == id_width_lp'(i)) begin
            cache_req_metadata_o =
               req_metadata_i[i*dcache_req_metadata_width_lp +: dcache_req_metadata_width_lp];
         end
      end

      // Handshake-type outputs stay low for the whole reset, which also
      // suppresses the completion of an abandoned transaction.
      if (!reset_i) begin
         unique case (state_q)
            e_idle: begin
               cache_req_v_o = rr_v;
               req_ready_o   = rr_grants & {num_req_p{cache_req_ready_i}};
            end
            e_meta: begin
               cache_req_metadata_v_o = owner_meta_v;
               if (cache_req_complete_i) req_complete_o[grant_id_q] = 1'b1;
            end
            e_wait: begin
               if (cache_req_complete_i) req_complete_o[grant_id_q] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy_o     = (state_q != e_idle);
   assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Directed bench for bp_be_cache_req_arbiter with default parameters
// (two requesters, 16-bit requests, 4-bit metadata).
module tb_bp_be_cache_req_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [31:0] req_i;
   logic [1:0]  req_v_i;
   logic [1:0]  req_ready_o;
   logic [7:0]  req_metadata_i;
   logic [1:0]  req_metadata_v_i;
   logic [1:0]  req_complete_o;
   logic [15:0] cache_req_o;
   logic        cache_req_v_o;
   logic        cache_req_ready_i;
   logic [3:0]  cache_req_metadata_o;
   logic        cache_req_metadata_v_o;
   logic        cache_req_complete_i;
   logic        busy_o;
   logic [0:0]  grant_id_o;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_i = ~clk_i;

   bp_be_cache_req_arbiter dut (
      .clk_i                  (clk_i),
      .reset_i                (reset_i),
      .req_i                  (req_i),
      .req_v_i                (req_v_i),
      .req_ready_o            (req_ready_o),
      .req_metadata_i         (req_metadata_i),
      .req_metadata_v_i       (req_metadata_v_i),
      .req_complete_o         (req_complete_o),
      .cache_req_o            (cache_req_o),
      .cache_req_v_o          (cache_req_v_o),
      .cache_req_ready_i      (cache_req_ready_i),
      .cache_req_metadata_o   (cache_req_metadata_o),
      .cache_req_metadata_v_o (cache_req_metadata_v_o),
      .cache_req_complete_i   (cache_req_complete_i),
      .busy_o                 (busy_o),
      .grant_id_o             (grant_id_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // One contended transaction; expects requester exp_id to win.
   task automatic txn(input int exp_id);
      logic [1:0] oh;
      oh = 2'(1 << exp_id);
      #1;
      chk("cont_ready", 32'(req_ready_o), 32'(oh));
      chk("cont_data", 32'(cache_req_o), (exp_id == 0) ? 32'hAAAA : 32'hBBBB);
      tick();
      chk("cont_grant", 32'(grant_id_o), 32'(exp_id));
      chk("cont_hold_ready", 32'(req_ready_o), 32'h0);
      chk("cont_hold_v", 32'(cache_req_v_o), 32'h0);
      req_metadata_v_i = 2'b11;
      #1;
      chk("cont_meta_v", 32'(cache_req_metadata_v_o), 32'h1);
      chk("cont_meta", 32'(cache_req_metadata_o), (exp_id == 0) ? 32'h3 : 32'h5);
      tick();
      req_metadata_v_i     = 2'b00;
      cache_req_complete_i = 1'b1;
      #1;
      chk("cont_complete", 32'(req_complete_o), 32'(oh));
      tick();
      cache_req_complete_i = 1'b0;
   endtask

   initial begin
      // Reset with every input active: handshake outputs must stay low.
      reset_i              = 1'b1;
      req_i                = {16'hBBBB, 16'hAAAA};
      req_v_i              = 2'b11;
      req_metadata_i       = {4'h5, 4'h3};
      req_metadata_v_i     = 2'b11;
      cache_req_ready_i    = 1'b1;
      cache_req_complete_i = 1'b1;
      tick();
      tick();
      chk("rst_req_v", 32'(cache_req_v_o), 32'h0);
      chk("rst_ready", 32'(req_ready_o), 32'h0);
      chk("rst_meta_v", 32'(cache_req_metadata_v_o), 32'h0);
      chk("rst_complete", 32'(req_complete_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_grant", 32'(grant_id_o), 32'h0);
      req_v_i              = 2'b00;
      req_metadata_v_i     = 2'b00;
      cache_req_complete_i = 1'b0;
      reset_i              = 1'b0;
      tick();

      // Single request from requester 0.
      req_v_i = 2'b01;
      #1;
      chk("single_v", 32'(cache_req_v_o), 32'h1);
      chk("single_ready", 32'(req_ready_o), 32'h1);
      chk("single_data", 32'(cache_req_o), 32'hAAAA);
      tick();
      req_v_i          = 2'b00;
      req_metadata_v_i = 2'b01;
      #1;
      chk("single_busy", 32'(busy_o), 32'h1);
      chk("single_meta_v", 32'(cache_req_metadata_v_o), 32'h1);
      chk("single_meta", 32'(cache_req_metadata_o), 32'h3);
      tick();
      req_metadata_v_i = 2'b00;
      #1;
      chk("single_wait1_cpl", 32'(req_complete_o), 32'h0);
      tick();
      chk("single_wait2_cpl", 32'(req_complete_o), 32'h0);
      tick();
      cache_req_complete_i = 1'b1;
      #1;
      chk("single_complete", 32'(req_complete_o), 32'h1);
      tick();
      cache_req_complete_i = 1'b0;
      #1;
      chk("single_idle_busy", 32'(busy_o), 32'h0);
      chk("single_pulse_end", 32'(req_complete_o), 32'h0);

      // Contention from reset: 0,1,0,1.
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      req_v_i = 2'b11;
      txn(0);
      txn(1);
      txn(0);
      txn(1);
      req_v_i = 2'b00;

      // Backpressure on requester 1.
      req_v_i           = 2'b10;
      cache_req_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_v", 32'(cache_req_v_o), 32'h1);
         chk("bp_ready", 32'(req_ready_o), 32'h0);
         chk("bp_busy", 32'(busy_o), 32'h0);
         tick();
      end
      cache_req_ready_i = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready_o), 32'h2);
      chk("bp_data", 32'(cache_req_o), 32'hBBBB);
      tick();
      req_v_i = 2'b00;
      chk("bp_grant", 32'(grant_id_o), 32'h1);

      // Stray metadata from non-owner 0 while 1 owns the port.
      req_metadata_v_i = 2'b01;
      #1;
      chk("stray_meta_v", 32'(cache_req_metadata_v_o), 32'h0);
      tick();
      chk("stray_still_meta", 32'(busy_o), 32'h1);
      req_metadata_v_i = 2'b10;
      #1;
      chk("owner_meta_v", 32'(cache_req_metadata_v_o), 32'h1);
      chk("owner_meta", 32'(cache_req_metadata_o), 32'h5);
      tick();
      req_metadata_v_i     = 2'b00;
      cache_req_complete_i = 1'b1;
      #1;
      chk("owner_complete", 32'(req_complete_o), 32'h2);
      tick();
      // Stray complete and metadata while idle.
      req_metadata_v_i = 2'b11;
      #1;
      chk("idle_cpl_ignored", 32'(req_complete_o), 32'h0);
      chk("idle_meta_ignored", 32'(cache_req_metadata_v_o), 32'h0);
      tick();
      chk("idle_stays", 32'(busy_o), 32'h0);
      cache_req_complete_i = 1'b0;
      req_metadata_v_i     = 2'b00;

      // Reset in e_wait after a grant to 0 (pointer would otherwise favour 1).
      req_v_i = 2'b01;
      tick();
      req_v_i          = 2'b00;
      req_metadata_v_i = 2'b01;
      tick();
      req_metadata_v_i = 2'b00;
      reset_i              = 1'b1;
      cache_req_complete_i = 1'b1;
      req_v_i              = 2'b11;
      #1;
      chk("rstwait_no_cpl", 32'(req_complete_o), 32'h0);
      chk("rstwait_no_v", 32'(cache_req_v_o), 32'h0);
      tick();
      reset_i              = 1'b0;
      cache_req_complete_i = 1'b0;
      #1;
      chk("rstwait_busy", 32'(busy_o), 32'h0);
      chk("rstwait_ready0", 32'(req_ready_o), 32'h1);
      tick();
      req_v_i = 2'b00;
      chk("rstwait_grant", 32'(grant_id_o), 32'h0);

      // Metadata and complete in the same e_meta cycle.
      req_metadata_v_i     = 2'b01;
      cache_req_complete_i = 1'b1;
      #1;
      chk("both_meta_v", 32'(cache_req_metadata_v_o), 32'h1);
      chk("both_complete", 32'(req_complete_o), 32'h1);
      tick();
      req_metadata_v_i     = 2'b00;
      cache_req_complete_i = 1'b0;
      #1;
      chk("both_idle", 32'(busy_o), 32'h0);
      chk("both_pulse_end", 32'(req_complete_o), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
